// File: rtl/solver_pkg.sv
// Shared types and sizing for the nonogram option pipeline.
package solver_pkg;

  localparam int unsigned MAX_LINES = 22;
  localparam int unsigned OPT_W     = 16;
  localparam int unsigned LINE_W    = 5;
  localparam int unsigned CNT_W     = 7;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [OPT_W-1:0]  option;
  } opt_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SNAP,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  function automatic cnt_t sat_cnt(input int unsigned v);
    return (v > 32'd127) ? cnt_t'(127) : cnt_t'(v);
  endfunction

endpackage

// File: rtl/opt_ring_buf.sv
// Circular option store: one write and one pop per cycle, head entry always visible.
module opt_ring_buf
  import solver_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  opt_entry_t               wr_data,
  input  logic                     rd_en,
  output opt_entry_t               rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  opt_entry_t    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_wr;
  logic          do_rd;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (occupancy != '0);
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (do_wr) tail <= tail + AW'(1);
      if (do_rd) head <= head + AW'(1);
      occupancy <= occupancy + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/option_line_queue.sv
// Option queue feeding the nonogram solver: loads all options, streams them per line
// with header words, re-enqueues put-backs and snapshots per-line counts each round.
module option_line_queue
  import solver_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned PB_LAT = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           num_rows,
  input  logic [3:0]                           num_cols,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  input  logic [LINE_W-1:0]                    load_line,
  input  logic [OPT_W-1:0]                     load_option,
  input  logic                                 load_done,
  output logic                                 started,
  output logic [OPT_W-1:0]                     option,
  output logic                                 option_valid,
  output logic                                 option_is_header,
  input  logic                                 option_ready,
  input  logic                                 put_back,
  output logic [MAX_LINES-1:0][CNT_W-1:0]      old_options_amnt,
  output logic [CNT_W-1:0]                     all_options_remaining,
  input  logic                                 solved,
  input  logic                                 unsolvable,
  output logic [7:0]                           round_cnt,
  output logic                                 overflow
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  state_t                             state, next_state;
  logic                               armed;
  logic [MAX_LINES-1:0][CNT_W-1:0]    live_cnt;
  logic [OCC_W-1:0]                   occ, round_total, popped, fetched;
  opt_entry_t                         head, wr_data, out_entry;
  logic                               full, wr_en, rd_en;
  logic                               out_valid, out_hdr, hdr_seen;
  logic [LINE_W-1:0]                  last_line, lines_active;
  opt_entry_t                         sl [PB_LAT];
  logic [PB_LAT-1:0]                  sl_v;
  logic [7:0]                         drain_cnt;
  logic in_load, line_ok, load_acc, ld_err, pb_ok, pb_err;
  logic consume, acc_opt, fetch_en, fetch_hdr, drain_end;

  opt_ring_buf #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (head),
    .full      (full),
    .occupancy (occ)
  );

  // armed keeps load_ready low while reset is held, so every output reads 0 in reset.
  assign in_load      = (state == IDLE) || (state == LOAD);
  assign lines_active = LINE_W'(num_rows) + LINE_W'(num_cols);
  assign line_ok      = (load_line < lines_active) && (load_line < LINE_W'(MAX_LINES));
  assign load_ready   = armed && in_load && !full;
  assign load_acc     = load_valid && load_ready && line_ok;
  assign ld_err       = load_valid && in_load && full;
  assign pb_ok        = put_back && ((state == STREAM) || (state == DRAIN)) && sl_v[PB_LAT-1] && !full;
  assign pb_err       = put_back && (state != DONE) && !pb_ok;
  assign wr_en        = load_acc || pb_ok;
  assign wr_data      = in_load ? '{line: load_line, option: load_option} : sl[PB_LAT-1];

  assign option_valid     = out_valid && (state == STREAM);
  assign option_is_header = option_valid && out_hdr;
  assign option           = out_hdr ? OPT_W'(out_entry.line) : out_entry.option;
  assign started          = (state == SNAP) && (round_cnt == '0);

  assign consume   = option_valid && option_ready;
  assign acc_opt   = consume && !out_hdr;
  assign drain_end = (state == DRAIN) && (drain_cnt == 8'(PB_LAT - 1));
  // The output register prefetches one word ahead, so the ring pops at fetch time.
  assign fetch_en  = (state == STREAM) && (next_state == STREAM) &&
                     (!out_valid || option_ready) && (fetched != round_total);
  assign fetch_hdr = !hdr_seen || (head.line != last_line);
  assign rd_en     = fetch_en && !fetch_hdr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_valid) next_state = LOAD;
      LOAD:    if (load_done) next_state = SNAP;
      SNAP:    next_state = STREAM;
      STREAM:  if ((popped == round_total) && !out_valid) next_state = DRAIN;
      DRAIN:   if (drain_end) next_state = ((occ == '0) && !pb_ok) ? DONE : SNAP;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if ((solved || unsolvable) && (state != IDLE)) next_state = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      armed                 <= 1'b0;
      live_cnt              <= '0;
      old_options_amnt      <= '0;
      all_options_remaining <= '0;
      round_total           <= '0;
      popped                <= '0;
      fetched               <= '0;
      hdr_seen              <= 1'b0;
      last_line             <= '0;
      out_valid             <= 1'b0;
      out_hdr               <= 1'b0;
      out_entry             <= '0;
      drain_cnt             <= '0;
      round_cnt             <= '0;
      overflow              <= 1'b0;
      sl_v                  <= '0;
      for (int unsigned i = 0; i < PB_LAT; i++) sl[i] <= '0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      if (ld_err || pb_err) overflow <= 1'b1;

      for (int unsigned i = 0; i < MAX_LINES; i++)
        live_cnt[i] <= live_cnt[i] + cnt_t'(wr_en && (wr_data.line == LINE_W'(i)))
                                   - cnt_t'(acc_opt && (out_entry.line == LINE_W'(i)));

      if (state == SNAP) begin
        old_options_amnt      <= live_cnt;
        all_options_remaining <= sat_cnt(32'(occ));
        round_total           <= occ;
        popped                <= '0;
        fetched               <= '0;
        hdr_seen              <= 1'b0;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : '0;
      if (drain_end) round_cnt <= round_cnt + 8'd1;

      if (fetch_en) begin
        if (fetch_hdr) begin
          hdr_seen  <= 1'b1;
          last_line <= head.line;
        end else begin
          fetched <= fetched + OCC_W'(1);
        end
      end
      if (acc_opt) popped <= popped + OCC_W'(1);

      if (next_state != STREAM) begin
        out_valid <= 1'b0;
      end else if (fetch_en) begin
        out_valid <= 1'b1;
        out_hdr   <= fetch_hdr;
        out_entry <= head;
      end else if (consume) begin
        out_valid <= 1'b0;
      end

      sl_v[0] <= acc_opt;
      sl[0]   <= out_entry;
      for (int unsigned i = 1; i < PB_LAT; i++) begin
        sl_v[i] <= sl_v[i-1];
        sl[i]   <= sl[i-1];
      end
    end
  end

endmodule

// File: tb/tb_option_line_queue.sv
// Directed bench for option_line_queue: table-driven round streams plus corner sequences.
module tb_option_line_queue;
  import solver_pkg::*;

  typedef struct packed {
    logic        hdr;
    logic [15:0] word;
    logic        keep;
  } vec_t;

  typedef struct packed {
    logic [4:0]  line;
    logic [15:0] opt;
  } ld_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst;
  logic [3:0]                        num_rows, num_cols;
  logic                              load_valid, load_ready, load_done;
  logic [4:0]                        load_line;
  logic [15:0]                       load_option;
  logic                              started;
  logic [15:0]                       option;
  logic                              option_valid, option_is_header, option_ready, put_back;
  logic [MAX_LINES-1:0][CNT_W-1:0]   old_options_amnt;
  logic [CNT_W-1:0]                  all_options_remaining;
  logic                              solved, unsolvable, overflow;
  logic [7:0]                        round_cnt;

  option_line_queue #(.DEPTH(512), .PB_LAT(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .num_rows              (num_rows),
    .num_cols              (num_cols),
    .load_valid            (load_valid),
    .load_ready            (load_ready),
    .load_line             (load_line),
    .load_option           (load_option),
    .load_done             (load_done),
    .started               (started),
    .option                (option),
    .option_valid          (option_valid),
    .option_is_header      (option_is_header),
    .option_ready          (option_ready),
    .put_back              (put_back),
    .old_options_amnt      (old_options_amnt),
    .all_options_remaining (all_options_remaining),
    .solved                (solved),
    .unsolvable            (unsolvable),
    .round_cnt             (round_cnt),
    .overflow              (overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int started_cnt = 0;

  always @(negedge clk) if (started === 1'b1) started_cnt++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
  endtask

  function automatic vec_t v(input logic h, input logic [15:0] w, input logic k);
    return '{hdr: h, word: w, keep: k};
  endfunction

  function automatic ld_t ld(input logic [4:0] l, input logic [15:0] o);
    return '{line: l, opt: o};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 0; load_done = 0; load_line = '0; load_option = '0;
    option_ready = 0; put_back = 0; solved = 0; unsolvable = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_entries(input ld_t t[$]);
    int bad = 0;
    foreach (t[i]) begin
      @(negedge clk);
      if (load_ready !== 1'b1) bad++;
      load_valid = 1; load_line = t[i].line; load_option = t[i].opt;
    end
    @(negedge clk);
    load_valid = 0; load_done = 1;
    @(negedge clk);
    load_done = 0;
    chk("load_ready while loading", 64'(bad), 64'd0);
  endtask

  // Streams one round with option_ready held high; put_back follows accepted words by 2 cycles.
  task automatic run_round(input string nm, input vec_t t[$], input bit no_keep,
                           input logic [5:0][6:0] ec, input int etot, input int ernd);
    int  idx  = 0;
    int  gaps = 0;
    bit  seen = 0;
    bit  d0 = 0, d1 = 0, k;
    option_ready = 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      k = 0;
      if (option_valid) begin
        if (!seen) begin
          seen = 1;
          for (int i = 0; i < 6; i++)
            chk($sformatf("%s old_cnt[%0d]", nm, i), 64'(old_options_amnt[i]), 64'(ec[i]));
          chk($sformatf("%s remaining", nm), 64'(all_options_remaining), 64'(etot));
          chk($sformatf("%s round_cnt", nm), 64'(round_cnt), 64'(ernd));
        end
        if (idx < t.size()) begin
          chk($sformatf("%s word%0d {hdr,opt}", nm, idx), {47'd0, option_is_header, option},
              {47'd0, t[idx].hdr, t[idx].word});
          k = !t[idx].hdr && t[idx].keep && !no_keep;
        end else begin
          chk($sformatf("%s extra word valid", nm), 64'(option_valid), 64'd0);
        end
        idx++;
      end else if (seen && idx < t.size()) begin
        gaps++;
      end
      put_back = d1; d1 = d0; d0 = k;
      if (idx >= t.size() && !d0 && !d1) break;
    end
    @(negedge clk);
    put_back = 0;
    option_ready = 0;
    chk($sformatf("%s words seen", nm), 64'(idx), 64'(t.size()));
    chk($sformatf("%s bubbles", nm), 64'(gaps), 64'd0);
  endtask

  task automatic check_idle_done(input string nm, input int ernd);
    int vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (option_valid !== 1'b0) vcnt++;
    end
    chk($sformatf("%s valid cycles", nm), 64'(vcnt), 64'd0);
    chk($sformatf("%s round_cnt", nm), 64'(round_cnt), 64'(ernd));
    chk($sformatf("%s load_ready", nm), 64'(load_ready), 64'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " option_valid"}, 64'(option_valid), 64'd0);
    chk({nm, " option_is_header"}, 64'(option_is_header), 64'd0);
    chk({nm, " option"}, 64'(option), 64'd0);
    chk({nm, " load_ready"}, 64'(load_ready), 64'd0);
    chk({nm, " started"}, 64'(started), 64'd0);
    chk({nm, " overflow"}, 64'(overflow), 64'd0);
    chk({nm, " round_cnt"}, 64'(round_cnt), 64'd0);
    chk({nm, " remaining"}, 64'(all_options_remaining), 64'd0);
    chk({nm, " old_cnt any"}, 64'(|old_options_amnt), 64'd0);
  endtask

  initial begin
    ld_t  tab[$];
    vec_t r1[$], r2[$];
    int   base, bad, vcnt;

    // bit i = cell i: "100" -> 1, "010" -> 2, "001" -> 4, "000" -> 0
    tab = '{ld(0,1), ld(0,2), ld(0,4), ld(1,1), ld(1,2), ld(1,4), ld(2,0), ld(3,0),
            ld(4,1), ld(4,2), ld(4,4), ld(5,1), ld(5,2), ld(5,4)};
    r1  = '{v(1,0,0), v(0,1,1), v(0,2,1), v(0,4,1), v(1,1,0), v(0,1,1), v(0,2,1), v(0,4,1),
            v(1,2,0), v(0,0,1), v(1,3,0), v(0,0,1), v(1,4,0), v(0,1,0), v(0,2,1), v(0,4,1),
            v(1,5,0), v(0,1,0), v(0,2,1), v(0,4,1)};
    r2  = '{v(1,0,0), v(0,1,1), v(0,2,1), v(0,4,1), v(1,1,0), v(0,1,1), v(0,2,1), v(0,4,1),
            v(1,2,0), v(0,0,1), v(1,3,0), v(0,0,1), v(1,4,0), v(0,2,1), v(0,4,1),
            v(1,5,0), v(0,2,1), v(0,4,1)};

    rst = 1'b0;
    num_rows = 4'd3; num_cols = 4'd3;
    load_valid = 0; load_done = 0; load_line = '0; load_option = '0;
    option_ready = 0; put_back = 0; solved = 0; unsolvable = 0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("load_ready after reset", 64'(load_ready), 64'd1);

    // Three rounds: drop col1/col2 "100", then keep all, then keep none.
    base = started_cnt;
    load_entries(tab);
    run_round("r1", r1, 1'b0, {7'd3, 7'd3, 7'd1, 7'd1, 7'd3, 7'd3}, 14, 0);
    chk("started pulses r1", 64'(started_cnt - base), 64'd1);
    run_round("r2", r2, 1'b0, {7'd2, 7'd2, 7'd1, 7'd1, 7'd3, 7'd3}, 12, 1);
    run_round("r3", r2, 1'b1, {7'd2, 7'd2, 7'd1, 7'd1, 7'd3, 7'd3}, 12, 2);
    chk("started pulses r3", 64'(started_cnt - base), 64'd1);
    check_idle_done("after r3", 3);
    chk("overflow after rounds", 64'(overflow), 64'd0);

    // No put-backs in round 1: straight to DONE.
    do_reset();
    load_entries(tab);
    run_round("nopb", r1, 1'b1, {7'd3, 7'd3, 7'd1, 7'd1, 7'd3, 7'd3}, 14, 0);
    check_idle_done("nopb done", 1);

    // Fill to capacity, then one extra load.
    do_reset();
    num_rows = 4'd11; num_cols = 4'd11;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (load_ready !== 1'b1) bad++;
      load_valid = 1; load_line = 5'(i % 22); load_option = 16'(i);
    end
    @(negedge clk);
    load_valid = 0;
    chk("fill load_ready while filling", 64'(bad), 64'd0);
    chk("fill load_ready at full", 64'(load_ready), 64'd0);
    chk("fill overflow before extra", 64'(overflow), 64'd0);
    @(negedge clk);
    load_valid = 1; load_line = 5'd1; load_option = 16'hBEEF;
    @(negedge clk);
    load_valid = 0;
    chk("fill overflow after extra", 64'(overflow), 64'd1);

    // put_back with nothing in the shift line.
    do_reset();
    num_rows = 4'd3; num_cols = 4'd3;
    chk("stray pb overflow before", 64'(overflow), 64'd0);
    put_back = 1;
    @(negedge clk);
    put_back = 0;
    @(negedge clk);
    chk("stray pb overflow after", 64'(overflow), 64'd1);

    // Stall, then unsolvable mid-stream, then asynchronous reset in DONE.
    do_reset();
    load_entries(tab);
    for (int i = 0; i < 20 && option_valid !== 1'b1; i++) @(negedge clk);
    chk("stall first valid", 64'(option_valid), 64'd1);
    repeat (3) @(negedge clk);
    chk("stall header held", {47'd0, option_is_header, option}, {47'd0, 1'b1, 16'd0});
    option_ready = 1;
    repeat (3) @(negedge clk);
    unsolvable = 1;
    @(negedge clk);
    unsolvable = 0;
    chk("unsolvable option_valid", 64'(option_valid), 64'd0);
    chk("unsolvable load_ready", 64'(load_ready), 64'd0);
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (option_valid !== 1'b0) vcnt++;
    end
    chk("unsolvable valid cycles", 64'(vcnt), 64'd0);
    chk("unsolvable remaining held", 64'(all_options_remaining), 64'd14);
    option_ready = 0;
    #2 rst = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clk);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
